// File: rtl/core_peripheral_responder_pkg.sv
// core_periph_pkg: shared command codes, widths and TX state type for the peripheral responder
package core_periph_pkg;
  localparam int CMD_WIDTH = 2;
  typedef enum logic [CMD_WIDTH-1:0] {CMD_REPORT = 2'd0, CMD_DATA = 2'd1, CMD_CTRL = 2'd2} cmd_t;
  typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_t;
endpackage

// File: rtl/core_peripheral_responder_if.sv
// core_peripheral_responder_if: core-side pulse bus plus host-side RX/TX handshakes
interface core_peripheral_responder_if #(parameter int DATA_WIDTH = 32);
  import core_periph_pkg::*;
  logic [CMD_WIDTH-1:0]  to_peripheral;
  logic [DATA_WIDTH-1:0] to_peripheral_data;
  logic                  to_peripheral_valid;
  logic [CMD_WIDTH-1:0]  from_peripheral;
  logic [DATA_WIDTH-1:0] from_peripheral_data;
  logic                  from_peripheral_valid;
  logic [CMD_WIDTH-1:0]  host_rx_cmd;
  logic [DATA_WIDTH-1:0] host_rx_data;
  logic                  host_rx_valid;
  logic                  host_rx_ready;
  logic [CMD_WIDTH-1:0]  host_tx_cmd;
  logic [DATA_WIDTH-1:0] host_tx_data;
  logic                  host_tx_valid;
  logic                  host_tx_ready;
  modport slave (
    input  to_peripheral, to_peripheral_data, to_peripheral_valid, host_rx_ready,
           host_tx_cmd, host_tx_data, host_tx_valid,
    output from_peripheral, from_peripheral_data, from_peripheral_valid,
           host_rx_cmd, host_rx_data, host_rx_valid, host_tx_ready
  );
  modport master (
    output to_peripheral, to_peripheral_data, to_peripheral_valid, host_rx_ready,
           host_tx_cmd, host_tx_data, host_tx_valid,
    input  from_peripheral, from_peripheral_data, from_peripheral_valid,
           host_rx_cmd, host_rx_data, host_rx_valid, host_tx_ready
  );
endinterface

// File: rtl/core_peripheral_responder_fifo.sv
// periph_sync_fifo: first-word-fall-through FIFO with occupancy, accepts a push when full if a pop happens alongside
module periph_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic do_push, do_pop;
  assign count   = wptr - rptr;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign rdata   = mem[rptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end
  // Full+pop writes into the slot being vacated; the read is combinational so it sees the old entry
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/core_peripheral_responder.sv
// core_peripheral_responder: core pulse capture into RX FIFO for the host, and host commands replayed as core pulses
// RESP_TIMESTAMP_EN adds a free-running cycle stamp to each RX entry and the host_rx_timestamp port.
module core_peripheral_responder
  import core_periph_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int TX_GAP     = 1,
  parameter int OVF_WIDTH  = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  core_peripheral_responder_if.slave    bus,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic [OVF_WIDTH-1:0]          overflow_count
`ifdef RESP_TIMESTAMP_EN
  , output logic [31:0]                 host_rx_timestamp
`endif
);
`ifdef RESP_TIMESTAMP_EN
  localparam int EW = CMD_WIDTH + DATA_WIDTH + 32;
`else
  localparam int EW = CMD_WIDTH + DATA_WIDTH;
`endif
  localparam logic [3:0] GAP_LAST = 4'(TX_GAP - 1);
  logic [EW-1:0] wdata, rdata;
  logic full, empty, drop, accept;
  tx_state_t state, state_nx;
  logic [3:0] gap_cnt;
`ifdef RESP_TIMESTAMP_EN
  logic [31:0] cycle;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle <= '0;
    else cycle <= cycle + 1'b1;
  end
  assign wdata = {bus.to_peripheral, bus.to_peripheral_data, cycle};
  assign {bus.host_rx_cmd, bus.host_rx_data, host_rx_timestamp} = rdata;
`else
  assign wdata = {bus.to_peripheral, bus.to_peripheral_data};
  assign {bus.host_rx_cmd, bus.host_rx_data} = rdata;
`endif
  periph_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock, .reset,
    .push(bus.to_peripheral_valid), .wdata,
    .pop(bus.host_rx_ready), .rdata,
    .count(rx_count), .full, .empty
  );
  assign bus.host_rx_valid = ~empty;
  assign drop = bus.to_peripheral_valid & full & ~bus.host_rx_ready;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) overflow_count <= '0;
    else if (drop && !(&overflow_count)) overflow_count <= overflow_count + 1'b1;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                    <= IDLE;
      gap_cnt                  <= '0;
      bus.from_peripheral      <= CMD_REPORT;
      bus.from_peripheral_data <= '0;
    end else begin
      state   <= state_nx;
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      if (accept) begin
        bus.from_peripheral      <= bus.host_tx_cmd;
        bus.from_peripheral_data <= bus.host_tx_data;
      end
    end
  end
  always_comb begin
    accept                    = state == IDLE && bus.host_tx_valid;
    bus.host_tx_ready         = state == IDLE;
    bus.from_peripheral_valid = state == SEND;
    state_nx = accept ? SEND :
               state == SEND ? (TX_GAP > 0 ? GAP : IDLE) :
               (state == GAP && gap_cnt == GAP_LAST) ? IDLE : state;
  end
endmodule

// File: tb/tb_core_peripheral_responder.sv
// tb_core_peripheral_responder: directed stimulus with queued expectations checked by a negedge monitor
module tb_core_peripheral_responder;
  localparam int DW = 32;
  typedef struct {logic [1:0] cmd; logic [31:0] data; logic [31:0] ts; bit chk_ts;} ent_t;
  logic clock = 0, reset = 0;
  always #5 clock = ~clock;
  core_peripheral_responder_if #(DW) bus();
  core_peripheral_responder_if #(DW) b0();
  logic [3:0] rx_count, rx_count0;
  logic [7:0] ovf, ovf0;
`ifdef RESP_TIMESTAMP_EN
  logic [31:0] ts, ts0;
`endif
  core_peripheral_responder #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .TX_GAP(1), .OVF_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .bus(bus), .rx_count(rx_count), .overflow_count(ovf)
`ifdef RESP_TIMESTAMP_EN
    , .host_rx_timestamp(ts)
`endif
  );
  core_peripheral_responder #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .TX_GAP(0), .OVF_WIDTH(8)) dut0 (
    .clock(clock), .reset(reset), .bus(b0), .rx_count(rx_count0), .overflow_count(ovf0)
`ifdef RESP_TIMESTAMP_EN
    , .host_rx_timestamp(ts0)
`endif
  );
  ent_t rxq[$], txq[$], txq0[$];
  ent_t me;
  int tx_t[$], tx_t0[$];
  int cyc = 0, pass_n = 0, total_n = 0;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask
  // Monitor: every host pop and every core-bound pulse is matched against the queued expectation
  always @(negedge clock) begin
    if (reset) begin
      if (bus.host_rx_valid && bus.host_rx_ready) begin
        if (rxq.size() == 0) begin
          total_n++;
          $display("FAIL rx_pop: unexpected pop of 0x%0h", bus.host_rx_data);
        end else begin
          me = rxq.pop_front();
          check("rx_cmd", bus.host_rx_cmd, me.cmd);
          check("rx_data", bus.host_rx_data, me.data);
`ifdef RESP_TIMESTAMP_EN
          if (me.chk_ts) check("rx_timestamp", ts, me.ts);
`endif
        end
      end
      if (bus.from_peripheral_valid) begin
        tx_t.push_back(cyc);
        if (txq.size() == 0) begin
          total_n++;
          $display("FAIL tx_pulse: unexpected pulse data 0x%0h", bus.from_peripheral_data);
        end else begin
          me = txq.pop_front();
          check("tx_cmd", bus.from_peripheral, me.cmd);
          check("tx_data", bus.from_peripheral_data, me.data);
        end
      end
      if (b0.from_peripheral_valid) begin
        tx_t0.push_back(cyc);
        if (txq0.size() == 0) begin
          total_n++;
          $display("FAIL tx0_pulse: unexpected pulse data 0x%0h", b0.from_peripheral_data);
        end else begin
          me = txq0.pop_front();
          check("tx0_data", b0.from_peripheral_data, me.data);
        end
      end
    end
  end
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic push(input logic [1:0] c, input logic [31:0] d, input bit keep, input logic [31:0] t, input bit ct);
    bus.to_peripheral = c;
    bus.to_peripheral_data = d;
    bus.to_peripheral_valid = 1;
    if (keep) rxq.push_back('{c, d, t, ct});
    tick();
    bus.to_peripheral_valid = 0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.to_peripheral = 0; bus.to_peripheral_data = 0; bus.to_peripheral_valid = 0;
    bus.host_rx_ready = 0; bus.host_tx_cmd = 0; bus.host_tx_data = 0; bus.host_tx_valid = 0;
    b0.to_peripheral = 0; b0.to_peripheral_data = 0; b0.to_peripheral_valid = 0;
    b0.host_rx_ready = 0; b0.host_tx_cmd = 0; b0.host_tx_data = 0; b0.host_tx_valid = 0;
    repeat (3) tick();
    check("reset_rx_count", rx_count, 0);
    check("reset_ovf", ovf, 0);
    check("reset_rx_valid", bus.host_rx_valid, 0);
    check("reset_tx_valid", bus.from_peripheral_valid, 0);
    reset = 1;
    tick();
    check("tx_ready_after_reset", bus.host_tx_ready, 1);
    // In-order delivery with one-cycle fall-through latency
    push(0, 32'h11, 1, 0, 0);
    check("latency_valid", bus.host_rx_valid, 1);
    check("latency_head", bus.host_rx_data, 32'h11);
    push(0, 32'h22, 1, 0, 0);
    push(0, 32'h33, 1, 0, 0);
    check("order_count", rx_count, 3);
    check("order_head", bus.host_rx_data, 32'h11);
    bus.host_rx_ready = 1;
    repeat (3) tick();
    bus.host_rx_ready = 0;
    check("order_drained_valid", bus.host_rx_valid, 0);
    check("order_drained_count", rx_count, 0);
    // Ten pulses into eight slots: last two are dropped
    for (int i = 1; i <= 10; i++) push(1, 32'(i), i <= 8, 0, 0);
    check("ovf_count", rx_count, 8);
    check("ovf_drops", ovf, 2);
    check("ovf_head", bus.host_rx_data, 1);
    bus.host_rx_ready = 1;
    push(2, 32'hAA, 1, 0, 0);
    bus.host_rx_ready = 0;
    check("fullpop_ovf", ovf, 2);
    check("fullpop_count", rx_count, 8);
    bus.host_rx_ready = 1;
    repeat (8) tick();
    bus.host_rx_ready = 0;
    check("fullpop_drained", bus.host_rx_valid, 0);
    check("fullpop_queue_left", rxq.size(), 0);
    for (int i = 0; i < 300; i++) push(0, 32'(i), i < 8, 0, 0);
    check("sat_ovf", ovf, 8'hFF);
    check("sat_count", rx_count, 8);
    // Asynchronous reset with a TX pulse in flight and the FIFO full
    bus.host_tx_cmd = 3; bus.host_tx_data = 32'h55; bus.host_tx_valid = 1;
    bus.to_peripheral_valid = 1;
    tick();
    check("inflight_tx_valid", bus.from_peripheral_valid, 1);
    #2 reset = 0;
    #1;
    check("midreset_rx_count", rx_count, 0);
    check("midreset_ovf", ovf, 0);
    check("midreset_rx_valid", bus.host_rx_valid, 0);
    check("midreset_fp", bus.from_peripheral, 0);
    check("midreset_fp_data", bus.from_peripheral_data, 0);
    check("midreset_fp_valid", bus.from_peripheral_valid, 0);
    bus.host_tx_valid = 0; bus.to_peripheral_valid = 0;
    rxq.delete();
    @(posedge clock);
    #1 reset = 1;
    check("release_tx_ready", bus.host_tx_ready, 1);
    check("release_rx_count", rx_count, 0);
`ifdef RESP_TIMESTAMP_EN
    repeat (5) tick();
    push(0, 32'h5, 1, 5, 1);
    repeat (3) tick();
    push(0, 32'h9, 1, 9, 1);
    bus.host_rx_ready = 1;
    repeat (2) tick();
    bus.host_rx_ready = 0;
`endif
    // TX: commands held valid; acceptances at P1, P4, P7 (gap 1) and every 2 cycles (gap 0)
    bus.host_tx_cmd = 1; bus.host_tx_data = 32'hDEADBEEF; bus.host_tx_valid = 1;
    txq.push_back('{1, 32'hDEADBEEF, 0, 0});
    b0.host_tx_cmd = 1; b0.host_tx_data = 32'hDEADBEEF; b0.host_tx_valid = 1;
    for (int i = 0; i < 4; i++) txq0.push_back('{1, 32'hDEADBEEF, 0, 0});
    tick();
    bus.host_tx_cmd = 2; bus.host_tx_data = 32'h12345678;
    txq.push_back('{2, 32'h12345678, 0, 0});
    repeat (3) tick();
    bus.host_tx_cmd = 3; bus.host_tx_data = 32'hCAFEF00D;
    txq.push_back('{3, 32'hCAFEF00D, 0, 0});
    repeat (3) tick();
    bus.host_tx_valid = 0; b0.host_tx_valid = 0;
    repeat (4) tick();
    check("tx_pulses", tx_t.size(), 3);
    for (int i = 1; i < tx_t.size(); i++) check("tx_spacing_gap1", tx_t[i] - tx_t[i-1], 3);
    check("tx0_pulses", tx_t0.size(), 4);
    for (int i = 1; i < tx_t0.size(); i++) check("tx_spacing_gap0", tx_t0[i] - tx_t0[i-1], 2);
    check("tx_queue_left", txq.size(), 0);
    check("tx_hold_data", bus.from_peripheral_data, 32'hCAFEF00D);
    check("tx_hold_cmd", bus.from_peripheral, 3);
    check("tx_idle_valid", bus.from_peripheral_valid, 0);
    check("tx_idle_ready", bus.host_tx_ready, 1);
    check("dut0_ovf", ovf0, 0);
    check("dut0_rx_count", rx_count0, 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
